cc_status_unit: RTL and testbench
=================================

// Module: cc_status_unit
// PURPOSE
//  Consumer end of the ALU condition-code interface. Latches Z/V/C/N from ALU_CC into the
//  status register (FLAGS), returns the registered carry to the ALU as Pre_C for ADC/SBB,
//  and resolves 16 branch conditions for the sequencer. A shadow stack saves/restores
//  FLAGS across interrupt entry/exit.
// PARAMETERS
//  SAVE_DEPTH  4   shadow-stack entries (>=1); pointer width = clog2(SAVE_DEPTH+1)
// PORTS
//  CLK        in   1  system clock, rising edge
//  RST        in   1  reset, asynchronous, active-high
//  Z,V,C,N    in   1  flags from ALU_CC, valid in the cycle CC_WE=1
//  CC_WE      in   1  update FLAGS from ALU flags, subject to CC_MASK
//  CC_MASK    in   4  per-flag update enable {N,Z,V,C}; 0 bits keep the old flag
//  PSW_LD     in   1  load FLAGS directly from PSW_IN
//  PSW_IN     in   4  {N,Z,V,C} load value
//  SAVE       in   1  push FLAGS onto shadow stack
//  RESTORE    in   1  pop shadow stack into FLAGS
//  BR_REQ     in   1  evaluate COND this cycle
//  COND       in   4  condition select (table below)
//  FLAGS      out  4  status register {N,Z,V,C}
//  Pre_C      out  1  = FLAGS[0]; carry-in to ALU_CC
//  BR_VALID   out  1  1-cycle pulse, cycle after BR_REQ
//  BR_TAKEN   out  1  condition result, meaningful while BR_VALID=1, else 0
//  STK_EMPTY  out  1  stack count == 0
//  STK_FULL   out  1  stack count == SAVE_DEPTH
//  STK_ERR    out  1  sticky: overflow or underflow occurred
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-sequence): FLAGS=0, Pre_C=0, BR_VALID=0, BR_TAKEN=0,
//    stack count=0 (STK_EMPTY=1, STK_FULL=0), STK_ERR=0. Stack entry contents don't-care.
//  - FLAGS next-state priority: RESTORE(valid) > PSW_LD > CC_WE > hold.
//    CC_WE: FLAGS[i] <= CC_MASK[i] ? alu_flag[i] : FLAGS[i]. Update visible 1 cycle after.
//  - Carry convention: C=1 = carry out on add / no borrow on subtract (ALU_CC definition).
//  - SAVE alone, count<DEPTH: push pre-update FLAGS, count+1. Same-cycle CC_WE/PSW_LD still
//    updates FLAGS; the pushed value is the old one.
//  - SAVE when full: no push, count unchanged, STK_ERR<=1.
//  - RESTORE alone, count>0: FLAGS<=top, count-1; same-cycle PSW_LD/CC_WE ignored.
//  - RESTORE when empty: no pop, FLAGS follows PSW_LD/CC_WE priority, STK_ERR<=1.
//  - SAVE+RESTORE same cycle, count>0: exchange - top<=current FLAGS, FLAGS<=old top,
//    count unchanged. Count==0: treated as a plain SAVE (push), no error.
//  - STK_ERR cleared only by RST.
//  - Branch: BR_REQ at cycle t -> BR_VALID=1, BR_TAKEN=cond(COND,F) at t+1; 1-cycle latency;
//    back-to-back BR_REQ gives back-to-back results. F = FLAGS register at t (pre-update).
//  - COND: 0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V |
//    8 HI C&!Z | 9 LS !C|Z | A GE N==V | B LT N!=V | C GT !Z&(N==V) | D LE Z|(N!=V) |
//    E AL 1 | F NV 0.
// CONFIGURATION
//  CC_FWD_EN defined: branch evaluation uses the FLAGS next-state value of cycle t
//    (same-cycle CC_WE/PSW_LD/RESTORE forwarded); latency still 1 cycle.
//  CC_FWD_EN undefined: evaluation uses the registered FLAGS (sequencer must insert one
//    cycle between a flag-setting op and a dependent branch).
// TESTING
//  1 RST mid-run with FLAGS=4'hF, count=2 -> all outputs to reset values immediately, async.
//  2 CC_WE, MASK=F, ALU 0x1234-0x1234 (Z=1,C=1,N=0,V=0) -> FLAGS=4'b0101, Pre_C=1;
//    next BR_REQ COND=0 -> BR_VALID=1, BR_TAKEN=1; COND=8 (HI) -> BR_TAKEN=0.
//  3 MASK=4'b0001, ALU C=0,Z=1 with FLAGS=4'b0101 -> FLAGS=4'b0100 (only C changed).
//  4 SAVE x4 (DEPTH=4) with FLAGS 1,2,3,4 -> STK_FULL=1; 5th SAVE -> STK_ERR=1, count 4;
//    RESTORE x4 -> FLAGS 4,3,2,1, STK_EMPTY=1; 5th RESTORE -> FLAGS hold, STK_ERR stays 1.
//  5 count=1 top=4'h3, FLAGS=4'hA, SAVE+RESTORE -> FLAGS=4'h3, top=4'hA, count=1.
//  6 FLAGS=0, CC_WE with Z=1 and BR_REQ COND=0 same cycle -> BR_TAKEN=0 without CC_FWD_EN,
//    BR_TAKEN=1 with CC_FWD_EN.

Source files
------------

// File: rtl/cc_status_unit_if.sv
// Condition-code bus between ALU_CC/sequencer (master) and the status unit (slave).
interface cc_status_unit_if;
   logic       Z;
   logic       V;
   logic       C;
   logic       N;
   logic       CC_WE;
   logic [3:0] CC_MASK;
   logic       PSW_LD;
   logic [3:0] PSW_IN;
   logic       SAVE;
   logic       RESTORE;
   logic       BR_REQ;
   logic [3:0] COND;
   logic [3:0] FLAGS;
   logic       Pre_C;
   logic       BR_VALID;
   logic       BR_TAKEN;
   logic       STK_EMPTY;
   logic       STK_FULL;
   logic       STK_ERR;

   modport master (
      output Z, V, C, N, CC_WE, CC_MASK, PSW_LD, PSW_IN,
      output SAVE, RESTORE, BR_REQ, COND,
      input  FLAGS, Pre_C, BR_VALID, BR_TAKEN,
      input  STK_EMPTY, STK_FULL, STK_ERR
   );

   modport slave (
      input  Z, V, C, N, CC_WE, CC_MASK, PSW_LD, PSW_IN,
      input  SAVE, RESTORE, BR_REQ, COND,
      output FLAGS, Pre_C, BR_VALID, BR_TAKEN,
      output STK_EMPTY, STK_FULL, STK_ERR
   );
endinterface

// File: rtl/cc_status_unit.sv
// Status register {N,Z,V,C}, shadow stack and branch-condition resolver.
// Optional CC_FWD_EN: branches evaluate the same-cycle FLAGS next-state.
module cc_status_unit #(
   parameter int SAVE_DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   cc_status_unit_if.slave  bus
);
   localparam int PW = $clog2(SAVE_DEPTH + 1);
   localparam logic [PW-1:0] ONE = PW'(1);
   localparam logic [PW-1:0] TOP = PW'(SAVE_DEPTH);

   logic [3:0]    flags_q;
   logic [3:0]    flags_d;
   logic [3:0]    alu_flags;
   logic [3:0]    eval_flags;
   logic [PW-1:0] cnt_q;
   logic [PW-1:0] top_idx;
   logic [3:0]    stk_mem [2**PW];
   logic          stk_empty;
   logic          stk_full;
   logic          do_push;
   logic          do_pop;
   logic          do_xchg;
   logic          do_err;
   logic          err_q;
   logic          br_valid_q;
   logic          br_taken_q;
   logic          cond_ok;

   assign alu_flags = {bus.N, bus.Z, bus.V, bus.C};
   assign stk_empty = (cnt_q == '0);
   assign stk_full  = (cnt_q == TOP);
   assign top_idx   = cnt_q - ONE;

   // SAVE+RESTORE on an empty stack degrades to a plain push
   assign do_xchg = bus.SAVE & bus.RESTORE & ~stk_empty;
   assign do_pop  = bus.RESTORE & ~bus.SAVE & ~stk_empty;
   assign do_push = bus.SAVE & ~do_xchg & ~stk_full;
   assign do_err  = (bus.SAVE & ~bus.RESTORE & stk_full)
                  | (bus.RESTORE & ~bus.SAVE & stk_empty);

   always_comb begin
      flags_d = flags_q;
      if (do_pop || do_xchg)
         flags_d = stk_mem[top_idx];
      else if (bus.PSW_LD)
         flags_d = bus.PSW_IN;
      else if (bus.CC_WE)
         flags_d = (alu_flags & bus.CC_MASK)
                 | (flags_q & ~bus.CC_MASK);
   end

`ifdef CC_FWD_EN
   assign eval_flags = flags_d;
`else
   assign eval_flags = flags_q;
`endif

   always_comb begin
      logic n, z, v, c;
      {n, z, v, c} = eval_flags;
      cond_ok = 1'b0;
      case (bus.COND)
         4'h0: cond_ok = z;
         4'h1: cond_ok = ~z;
         4'h2: cond_ok = c;
         4'h3: cond_ok = ~c;
         4'h4: cond_ok = n;
         4'h5: cond_ok = ~n;
         4'h6: cond_ok = v;
         4'h7: cond_ok = ~v;
         4'h8: cond_ok = c & ~z;
         4'h9: cond_ok = ~c | z;
         4'hA: cond_ok = (n == v);
         4'hB: cond_ok = (n != v);
         4'hC: cond_ok = ~z & (n == v);
         4'hD: cond_ok = z | (n != v);
         4'hE: cond_ok = 1'b1;
         4'hF: cond_ok = 1'b0;
         default: cond_ok = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         flags_q    <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         br_valid_q <= 1'b0;
         br_taken_q <= 1'b0;
      end else begin
         flags_q    <= flags_d;
         br_valid_q <= bus.BR_REQ;
         br_taken_q <= bus.BR_REQ & cond_ok;
         if (do_push)
            cnt_q <= cnt_q + ONE;
         else if (do_pop)
            cnt_q <= top_idx;
         if (do_err)
            err_q <= 1'b1;
      end
   end

   // Entry contents are don't-care after reset, so no reset here
   always_ff @(posedge CLK) begin
      if (do_push)
         stk_mem[cnt_q] <= flags_q;
      else if (do_xchg)
         stk_mem[top_idx] <= flags_q;
   end

   assign bus.FLAGS     = flags_q;
   assign bus.Pre_C     = flags_q[0];
   assign bus.BR_VALID  = br_valid_q;
   assign bus.BR_TAKEN  = br_taken_q;
   assign bus.STK_EMPTY = stk_empty;
   assign bus.STK_FULL  = stk_full;
   assign bus.STK_ERR   = err_q;
endmodule

// File: tb/tb_cc_status_unit.sv
// Bench for cc_status_unit: vector table, directed corner sequences, random vs queue model.
module tb_cc_status_unit;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   cc_status_unit_if bus();

   cc_status_unit #(.SAVE_DEPTH(DEPTH)) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   logic [3:0] m_flags;
   logic [3:0] m_stk [$];
   bit         m_err;
   bit         m_bv;
   bit         m_bt;

   typedef struct {
      logic       cc_we;
      logic [3:0] mask;
      logic [3:0] alu;
      logic       psw_ld;
      logic [3:0] psw;
      logic       save;
      logic       restore;
      logic       br;
      logic [3:0] cond;
      logic [3:0] e_flags;
      logic       e_bv;
      logic       e_bt;
   } vec_t;

   vec_t tbl [12];

   function automatic bit cond_true(logic [3:0] cs, logic [3:0] f);
      bit n, z, v, c;
      n = f[3]; z = f[2]; v = f[1]; c = f[0];
      case (cs)
         0: return z;
         1: return !z;
         2: return c;
         3: return !c;
         4: return n;
         5: return !n;
         6: return v;
         7: return !v;
         8: return c && !z;
         9: return !c || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(logic cc_we, logic [3:0] mask, logic [3:0] alu,
                         logic psw_ld, logic [3:0] psw, logic save,
                         logic restore, logic br, logic [3:0] cond);
      bus.CC_WE = cc_we;
      bus.CC_MASK = mask;
      {bus.N, bus.Z, bus.V, bus.C} = alu;
      bus.PSW_LD = psw_ld;
      bus.PSW_IN = psw;
      bus.SAVE = save;
      bus.RESTORE = restore;
      bus.BR_REQ = br;
      bus.COND = cond;
   endtask

   task automatic idle();
      set_in(0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0);
   endtask

   task automatic model_reset();
      m_flags = 4'h0;
      m_stk.delete();
      m_err = 0;
      m_bv = 0;
      m_bt = 0;
   endtask

   task automatic chk_model();
      chk("flags", bus.FLAGS, m_flags);
      chk("pre_c", {3'b0, bus.Pre_C}, {3'b0, m_flags[0]});
      chk("br_valid", {3'b0, bus.BR_VALID}, {3'b0, m_bv});
      chk("br_taken", {3'b0, bus.BR_TAKEN}, {3'b0, m_bt});
      chk("stk_empty", {3'b0, bus.STK_EMPTY}, {3'b0, m_stk.size() == 0});
      chk("stk_full", {3'b0, bus.STK_FULL}, {3'b0, m_stk.size() == DEPTH});
      chk("stk_err", {3'b0, bus.STK_ERR}, {3'b0, m_err});
   endtask

   // Advance one clock with the current inputs, stepping the model alongside
   task automatic tick();
      logic [3:0] cur, nf, alu, ef;
      int sz;
      cur = m_flags;
      nf = cur;
      sz = m_stk.size();
      alu = {bus.N, bus.Z, bus.V, bus.C};
      if (bus.SAVE && bus.RESTORE && sz > 0) begin
         nf = m_stk[sz-1];
         m_stk[sz-1] = cur;
      end else begin
         if (bus.RESTORE && !bus.SAVE && sz > 0)
            nf = m_stk.pop_back();
         else if (bus.PSW_LD)
            nf = bus.PSW_IN;
         else if (bus.CC_WE)
            nf = (alu & bus.CC_MASK) | (cur & ~bus.CC_MASK);
         if (bus.SAVE) begin
            if (sz < DEPTH) m_stk.push_back(cur);
            else m_err = 1;
         end else if (bus.RESTORE && sz == 0) begin
            m_err = 1;
         end
      end
`ifdef CC_FWD_EN
      ef = nf;
`else
      ef = cur;
`endif
      m_bv = bus.BR_REQ;
      m_bt = bus.BR_REQ && cond_true(bus.COND, ef);
      m_flags = nf;
      @(posedge clk);
      #1;
      chk_model();
   endtask

   // Asynchronous reset pulse placed mid-cycle, checked before any edge
   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_flags", bus.FLAGS, 4'h0);
      chk("rst_pre_c", {3'b0, bus.Pre_C}, 4'h0);
      chk("rst_bv", {3'b0, bus.BR_VALID}, 4'h0);
      chk("rst_bt", {3'b0, bus.BR_TAKEN}, 4'h0);
      chk("rst_empty", {3'b0, bus.STK_EMPTY}, 4'h1);
      chk("rst_full", {3'b0, bus.STK_FULL}, 4'h0);
      chk("rst_err", {3'b0, bus.STK_ERR}, 4'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      idle();
      model_reset();
      tbl[0]  = '{1, 4'hF, 4'b0101, 0, 4'h0, 0, 0, 0, 4'h0, 4'b0101, 0, 0};
      tbl[1]  = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'h0, 4'b0101, 1, 1};
      tbl[2]  = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'h8, 4'b0101, 1, 0};
      tbl[3]  = '{1, 4'h1, 4'b0100, 0, 4'h0, 0, 0, 0, 4'h0, 4'b0100, 0, 0};
      tbl[4]  = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'h3, 4'b0100, 1, 1};
      tbl[5]  = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'hF, 4'b0100, 1, 0};
      tbl[6]  = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'hE, 4'b0100, 1, 1};
      tbl[7]  = '{0, 4'h0, 4'h0,    1, 4'hA, 0, 0, 0, 4'h0, 4'hA,    0, 0};
      tbl[8]  = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'hA, 4'hA,    1, 1};
      tbl[9]  = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'hC, 4'hA,    1, 1};
      tbl[10] = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 1, 4'hB, 4'hA,    1, 0};
      tbl[11] = '{0, 4'h0, 4'h0,    0, 4'h0, 0, 0, 0, 4'h0, 4'hA,    0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk_model();
      rst = 1'b0;

      foreach (tbl[i]) begin
         set_in(tbl[i].cc_we, tbl[i].mask, tbl[i].alu, tbl[i].psw_ld,
                tbl[i].psw, tbl[i].save, tbl[i].restore, tbl[i].br,
                tbl[i].cond);
         tick();
         chk($sformatf("tbl%0d_flags", i), bus.FLAGS, tbl[i].e_flags);
         chk($sformatf("tbl%0d_bv", i), {3'b0, bus.BR_VALID},
             {3'b0, tbl[i].e_bv});
         chk($sformatf("tbl%0d_bt", i), {3'b0, bus.BR_TAKEN},
             {3'b0, tbl[i].e_bt});
      end

      // mid-run reset with FLAGS=F, count=2, branch in flight
      set_in(0, 4'h0, 4'h0, 1, 4'hF, 1, 0, 0, 4'h0);
      tick();
      set_in(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 1, 4'hE);
      tick();
      chk("pre_rst_flags", bus.FLAGS, 4'hF);
      chk("pre_rst_bv", {3'b0, bus.BR_VALID}, 4'h1);
      idle();
      pulse_reset();

      // fill, overflow, drain, underflow
      set_in(0, 4'h0, 4'h0, 1, 4'h1, 0, 0, 0, 4'h0);
      tick();
      for (int k = 2; k <= 4; k++) begin
         set_in(0, 4'h0, 4'h0, 1, 4'(k), 1, 0, 0, 4'h0);
         tick();
      end
      set_in(0, 4'h0, 4'h0, 0, 4'h0, 1, 0, 0, 4'h0);
      tick();
      chk("full4", {3'b0, bus.STK_FULL}, 4'h1);
      chk("err_before_ovf", {3'b0, bus.STK_ERR}, 4'h0);
      tick();
      chk("ovf_err", {3'b0, bus.STK_ERR}, 4'h1);
      chk("ovf_full", {3'b0, bus.STK_FULL}, 4'h1);
      for (int k = 4; k >= 1; k--) begin
         set_in(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0);
         tick();
         chk($sformatf("pop%0d", k), bus.FLAGS, 4'(k));
      end
      chk("drained", {3'b0, bus.STK_EMPTY}, 4'h1);
      tick();
      chk("unf_hold", bus.FLAGS, 4'h1);
      chk("unf_err", {3'b0, bus.STK_ERR}, 4'h1);
      idle();
      pulse_reset();

      // exchange with count=1
      set_in(0, 4'h0, 4'h0, 1, 4'h3, 0, 0, 0, 4'h0);
      tick();
      set_in(0, 4'h0, 4'h0, 1, 4'hA, 1, 0, 0, 4'h0);
      tick();
      set_in(0, 4'h0, 4'h0, 0, 4'h0, 1, 1, 0, 4'h0);
      tick();
      chk("xchg_flags", bus.FLAGS, 4'h3);
      chk("xchg_not_empty", {3'b0, bus.STK_EMPTY}, 4'h0);
      set_in(0, 4'h0, 4'h0, 0, 4'h0, 0, 1, 0, 4'h0);
      tick();
      chk("xchg_top", bus.FLAGS, 4'hA);
      chk("xchg_empty", {3'b0, bus.STK_EMPTY}, 4'h1);
      chk("xchg_no_err", {3'b0, bus.STK_ERR}, 4'h0);
      // SAVE+RESTORE on empty is a plain push without error
      set_in(0, 4'h0, 4'h0, 0, 4'h0, 1, 1, 0, 4'h0);
      tick();
      chk("sr_empty_push", {3'b0, bus.STK_EMPTY}, 4'h0);
      chk("sr_empty_err", {3'b0, bus.STK_ERR}, 4'h0);
      idle();
      pulse_reset();

      // same-cycle flag update and branch
      set_in(1, 4'hF, 4'b0100, 0, 4'h0, 0, 0, 1, 4'h0);
      tick();
`ifdef CC_FWD_EN
      chk("fwd_taken", {3'b0, bus.BR_TAKEN}, 4'h1);
`else
      chk("nofwd_taken", {3'b0, bus.BR_TAKEN}, 4'h0);
`endif
      chk("fwd_flags", bus.FLAGS, 4'b0100);
      idle();
      tick();

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(299) == 0) begin
            idle();
            pulse_reset();
         end
         set_in($urandom_range(1), 4'($urandom), 4'($urandom),
                $urandom_range(3) == 0, 4'($urandom),
                $urandom_range(2) == 0, $urandom_range(2) == 0,
                $urandom_range(1), 4'($urandom));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
